regfile_sb: RTL and testbench

- Parametrised successor to the RV32I integer register file: configurable data width and register count (RV32I/RV32E), two combinational read ports, one write port.
- Adds a per-register pending scoreboard so the pipeline can detect RAW hazards on in-flight writebacks.
- Adds a sequential clear sweep (one register per cycle) for context/debug clear without asserting reset.
- Sits between decode (reads, issue marking) and writeback (write, pending clear).

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_scoreboard.sv | 43 ++++
 rtl/regfile_sb.sv | 131 +++++++++++++
 tb/tb_regfile_sb.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the regfile_sb register file slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  // Clear-sweep controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } rf_state_t;

  // RV32I defaults; NREGS may be overridden to 16 for RV32E
  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set on issue, cleared on writeback or by the clear sweep.
// Latency: updates visible the cycle after the request; read-out is combinational.
// Backpressure: none; the caller gates set/clear/sweep with the controller state.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic          sweep_en,
  input  logic [AW-1:0] sweep_idx,
  input  logic [AW-1:0] rd1_idx,
  input  logic [AW-1:0] rd2_idx,
  output logic          rd1_pend,
  output logic          rd2_pend
);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;

  // Next pending vector: writeback clears, then issue sets (newer producer wins), sweep clears last
  always_comb begin
    pend_nxt = pend;
    if (clr_en)   pend_nxt[clr_idx]   = 1'b0;
    if (set_en)   pend_nxt[set_idx]   = 1'b1;
    if (sweep_en) pend_nxt[sweep_idx] = 1'b0;
    pend_nxt[0] = 1'b0;
  end

  // Pending register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend <= '0;
    else       pend <= pend_nxt;
  end

  assign rd1_pend = pend[rd1_idx];
  assign rd2_pend = pend[rd2_idx];

endmodule

// File: rtl/regfile_sb.sv
// Integer register file (XLEN x NREGS), 2 combinational read ports, 1 write port, pending scoreboard, clear sweep.
// Latency: reads combinational; write/issue take effect next edge; clear sweep takes NREGS cycles plus one DONE cycle.
// Backpressure: ready=0 during CLEAR/DONE, where writes, issues and clr_req are dropped. Macro REGFILE_WRITE_BYPASS_EN enables write-through forwarding.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int NREGS = NREGS_DEFAULT,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_pend,
  output logic            rs2_pend,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            clr_req,
  output logic            ready,
  output logic            clr_done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_t       state, state_nxt;
  logic [AW-1:0]   ptr, ptr_nxt;
  logic [XLEN-1:0] regs [NREGS];

  logic wr_fire, iss_fire, sweep;
  logic [XLEN-1:0] rs1_raw, rs2_raw;
  logic            rs1_pend_raw, rs2_pend_raw;

  // Writes and issues only count in IDLE and never target x0
  assign wr_fire  = (state == IDLE) && wr_en  && (wr_addr != '0);
  assign iss_fire = (state == IDLE) && iss_en && (iss_rd  != '0);
  assign sweep    = (state == CLEAR);

  // Controller state and sweep pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state and status outputs; DONE is left on the last index, not on pointer wrap
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    ready     = 1'b0;
    clr_done  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (clr_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        clr_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data array: sweep clears one entry per cycle, otherwise accept the writeback
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (sweep) begin
      regs[ptr] <= '0;
    end else if (wr_fire) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_en    (iss_fire),
    .set_idx   (iss_rd),
    .clr_en    (wr_fire),
    .clr_idx   (wr_addr),
    .sweep_en  (sweep),
    .sweep_idx (ptr),
    .rd1_idx   (rs1_addr),
    .rd2_idx   (rs2_addr),
    .rd1_pend  (rs1_pend_raw),
    .rd2_pend  (rs2_pend_raw)
  );

  // x0 always reads as zero regardless of stored contents
  assign rs1_raw = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign rs2_raw = (rs2_addr == '0) ? '0 : regs[rs2_addr];

`ifdef REGFILE_WRITE_BYPASS_EN
  logic byp1, byp2;

  // Forward the in-flight writeback to matching read ports in the same cycle
  assign byp1     = wr_fire && (wr_addr == rs1_addr);
  assign byp2     = wr_fire && (wr_addr == rs2_addr);
  assign rs1_data = byp1 ? wr_data : rs1_raw;
  assign rs2_data = byp2 ? wr_data : rs2_raw;
  assign rs1_pend = byp1 ? 1'b0 : rs1_pend_raw;
  assign rs2_pend = byp2 ? 1'b0 : rs2_pend_raw;
`else
  assign rs1_data = rs1_raw;
  assign rs2_data = rs2_raw;
  assign rs1_pend = rs1_pend_raw;
  assign rs2_pend = rs2_pend_raw;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (RV32I instance plus an RV32E instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // RV32I instance
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_rd;
  logic [31:0] rs1_data, rs2_data, wr_data;
  logic        rs1_pend, rs2_pend, wr_en, iss_en, clr_req, ready, clr_done;

  // RV32E instance
  logic [3:0]  e_rs1_addr, e_rs2_addr, e_wr_addr, e_iss_rd;
  logic [31:0] e_rs1_data, e_rs2_data, e_wr_data;
  logic        e_rs1_pend, e_rs2_pend, e_wr_en, e_iss_en, e_clr_req, e_ready, e_clr_done;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_sb dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_pend(rs1_pend), .rs2_pend(rs2_pend),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .clr_req(clr_req), .ready(ready), .clr_done(clr_done)
  );

  regfile_sb #(.XLEN(32), .NREGS(16)) dut_e (
    .clk(clk), .reset(reset),
    .rs1_addr(e_rs1_addr), .rs2_addr(e_rs2_addr),
    .rs1_data(e_rs1_data), .rs2_data(e_rs2_data),
    .rs1_pend(e_rs1_pend), .rs2_pend(e_rs2_pend),
    .wr_en(e_wr_en), .wr_addr(e_wr_addr), .wr_data(e_wr_data),
    .iss_en(e_iss_en), .iss_rd(e_iss_rd),
    .clr_req(e_clr_req), .ready(e_ready), .clr_done(e_clr_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic issue_reg(input logic [4:0] a);
    iss_en = 1'b1; iss_rd = a;
    tick();
    iss_en = 1'b0;
  endtask

  task automatic test_reset;
    bit seen_done;
    // State right after power-on reset
    rs1_addr = 5'd3; rs2_addr = 5'd9;
    #1;
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_chk++; if (clr_done !== 1'b0) begin n_fail++; $display("FAIL reset_clr_done: got %b want 0", clr_done); end
    n_chk++; if (rs1_data !== 32'h0 || rs1_pend !== 1'b0)
      begin n_fail++; $display("FAIL reset_rs1: got %h/%b want 0/0", rs1_data, rs1_pend); end
    // Abort a sweep at ptr=5 with reset
    write_reg(5'd20, 32'h0000_1234);
    issue_reg(5'd25);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    repeat (5) tick();
    rs1_addr = 5'd20; rs2_addr = 5'd25;
    #2 reset = 1'b1;
    #1;
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midsweep_reset_ready: got %b want 1", ready); end
    n_chk++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL midsweep_reset_x20: got %h want 0", rs1_data); end
    n_chk++; if (rs2_pend !== 1'b0) begin n_fail++; $display("FAIL midsweep_reset_pend25: got %b want 0", rs2_pend); end
    tick();
    #2 reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (clr_done === 1'b1 || ready !== 1'b1) seen_done = 1'b1;
    end
    n_chk++; if (seen_done) begin n_fail++; $display("FAIL midsweep_no_done: got pulse/busy want idle"); end
  endtask

  task automatic test_write_read;
    write_reg(5'd7, 32'hDEAD_BEEF);
    rs1_addr = 5'd7; #1;
    n_chk++; if (rs1_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_x7: got %h want deadbeef", rs1_data); end
    write_reg(5'd0, 32'h0000_0001);
    rs2_addr = 5'd0; #1;
    n_chk++; if (rs2_data !== 32'h0) begin n_fail++; $display("FAIL wr_x0: got %h want 0", rs2_data); end
    issue_reg(5'd0);
    n_chk++; if (rs2_pend !== 1'b0) begin n_fail++; $display("FAIL iss_x0_pend: got %b want 0", rs2_pend); end
  endtask

  task automatic test_scoreboard;
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    issue_reg(5'd5);
    n_chk++; if (rs1_pend !== 1'b1 || rs2_pend !== 1'b1)
      begin n_fail++; $display("FAIL sb_issue: got %b%b want 11", rs1_pend, rs2_pend); end
    write_reg(5'd5, 32'h0000_0033);
    n_chk++; if (rs1_pend !== 1'b0 || rs1_data !== 32'h33)
      begin n_fail++; $display("FAIL sb_wb: got %b/%h want 0/33", rs1_pend, rs1_data); end
    iss_en = 1'b1; iss_rd = 5'd5;
    write_reg(5'd5, 32'h0000_0010);
    iss_en = 1'b0;
    n_chk++; if (rs1_pend !== 1'b1 || rs1_data !== 32'h10)
      begin n_fail++; $display("FAIL sb_same_cycle: got %b/%h want 1/10", rs1_pend, rs1_data); end
    write_reg(5'd5, 32'h0000_0010);
  endtask

  task automatic test_back_to_back;
    write_reg(5'd1, 32'h1111_0001);
    write_reg(5'd2, 32'h2222_0002);
    write_reg(5'd3, 32'h3333_0003);
    rs1_addr = 5'd1; rs2_addr = 5'd3; #1;
    n_chk++; if (rs1_data !== 32'h1111_0001 || rs2_data !== 32'h3333_0003)
      begin n_fail++; $display("FAIL b2b_x1_x3: got %h/%h want 11110001/33330003", rs1_data, rs2_data); end
    rs1_addr = 5'd2; #1;
    n_chk++; if (rs1_data !== 32'h2222_0002) begin n_fail++; $display("FAIL b2b_x2: got %h want 22220002", rs1_data); end
  endtask

  task automatic test_clear_sweep;
    int nrdy, npulse, first;
    bit bad;
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hFFFF_FFFF);
    issue_reg(5'd3);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    // Hold a write and an issue throughout; both must be dropped
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h5555_5555;
    iss_en = 1'b1; iss_rd = 5'd31;
    rs2_addr = 5'd20;
    nrdy = 0; npulse = 0; first = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (ready !== 1'b1) nrdy++;
      if (cyc == 5) begin
        n_chk++; if (rs2_data !== 32'hFFFF_FFFF)
          begin n_fail++; $display("FAIL sweep_partial_x20: got %h want ffffffff", rs2_data); end
      end
      if (clr_done === 1'b1) begin
        npulse++;
        if (first == 0) first = cyc;
        wr_en = 1'b0; iss_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0; iss_en = 1'b0;
    n_chk++; if (nrdy != 33) begin n_fail++; $display("FAIL sweep_busy_cycles: got %0d want 33", nrdy); end
    n_chk++; if (first != 33 || npulse != 1)
      begin n_fail++; $display("FAIL sweep_done_pulse: got cycle %0d count %0d want 33/1", first, npulse); end
    bad = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); #1;
      if (rs1_data !== 32'h0 || rs1_pend !== 1'b0) bad = 1'b1;
    end
    n_chk++; if (bad) begin n_fail++; $display("FAIL sweep_all_zero: got nonzero data or pend want all 0"); end
  endtask

  task automatic test_rv32e;
    int nrdy, first;
    e_wr_en = 1'b1; e_wr_addr = 4'd15; e_wr_data = 32'hCAFE_F00D;
    tick();
    e_wr_en = 1'b0;
    e_rs1_addr = 4'd15; #1;
    n_chk++; if (e_rs1_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL e_wr_x15: got %h want cafef00d", e_rs1_data); end
    e_clr_req = 1'b1; tick(); e_clr_req = 1'b0;
    nrdy = 0; first = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (e_ready !== 1'b1) nrdy++;
      if (e_clr_done === 1'b1 && first == 0) first = cyc;
      tick();
    end
    n_chk++; if (nrdy != 17 || first != 17)
      begin n_fail++; $display("FAIL e_sweep_len: got busy %0d done@%0d want 17/17", nrdy, first); end
    n_chk++; if (e_rs1_data !== 32'h0) begin n_fail++; $display("FAIL e_sweep_x15: got %h want 0", e_rs1_data); end
  endtask

  task automatic test_bypass;
    write_reg(5'd9, 32'h0000_0011);
    issue_reg(5'd9);
    rs1_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5_A5A5;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    n_chk++; if (rs1_data !== 32'hA5A5_A5A5 || rs1_pend !== 1'b0)
      begin n_fail++; $display("FAIL bypass_same_cycle: got %h/%b want a5a5a5a5/0", rs1_data, rs1_pend); end
`else
    n_chk++; if (rs1_data !== 32'h0000_0011 || rs1_pend !== 1'b1)
      begin n_fail++; $display("FAIL nobypass_same_cycle: got %h/%b want 00000011/1", rs1_data, rs1_pend); end
`endif
    tick();
    wr_en = 1'b0; #1;
    n_chk++; if (rs1_data !== 32'hA5A5_A5A5 || rs1_pend !== 1'b0)
      begin n_fail++; $display("FAIL bypass_next_cycle: got %h/%b want a5a5a5a5/0", rs1_data, rs1_pend); end
  endtask

  initial begin
    rs1_addr = '0; rs2_addr = '0; wr_addr = '0; iss_rd = '0; wr_data = '0;
    wr_en = 1'b0; iss_en = 1'b0; clr_req = 1'b0;
    e_rs1_addr = '0; e_rs2_addr = '0; e_wr_addr = '0; e_iss_rd = '0; e_wr_data = '0;
    e_wr_en = 1'b0; e_iss_en = 1'b0; e_clr_req = 1'b0;
    #12 reset = 1'b0;
    test_reset();
    test_write_read();
    test_scoreboard();
    test_back_to_back();
    test_clear_sweep();
    test_rv32e();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
